// File: rtl/lfsr.sv
// Fibonacci LFSR serial PRBS source: seed load on ld&en, one shift per enabled edge, registered MSB out.
// Optional macro LFSR_LOCKUP_RECOVERY_EN reseeds from the all-zero state and adds a lockup pulse output.
module lfsr #(
    parameter int                    LFSR_WIDTH      = 11,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = 11'b10100000000,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED       = 11'b11011011011
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ld,
    input  logic en,
    output logic dout
`ifdef LFSR_LOCKUP_RECOVERY_EN
    ,
    output logic lockup
`endif
);

    logic [LFSR_WIDTH-1:0] state;
    logic [LFSR_WIDTH-1:0] next_state;
    logic                  fb;

    assign fb = ^(state & LFSR_POLYNOMIAL);

`ifdef LFSR_LOCKUP_RECOVERY_EN
    logic recover;

    // A step out of the all-zero state would stay stuck, so reseed instead.
    assign recover = en && !ld && (state == '0);

    always_comb begin
        next_state = state;
        if (en) begin
            if (ld || recover) begin
                next_state = LFSR_SEED;
            end else begin
                next_state = {state[LFSR_WIDTH-2:0], fb};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lockup <= 1'b0;
        end else begin
            lockup <= recover;
        end
    end
`else
    always_comb begin
        next_state = state;
        if (en) begin
            if (ld) begin
                next_state = LFSR_SEED;
            end else begin
                next_state = {state[LFSR_WIDTH-2:0], fb};
            end
        end
    end
`endif

    // dout takes the MSB from before the update, so the load edge emits the old state's MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
            dout  <= 1'b0;
        end else begin
            state <= next_state;
            if (en) begin
                dout <= state[LFSR_WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: directed steps plus random en/ld traffic against a recurrence-based sequence model.
// Build with or without LFSR_LOCKUP_RECOVERY_EN; the bench follows the same macro.
module tb_lfsr;

    localparam int          W    = 11;
    localparam logic [W-1:0] POLY = 11'b10100000000;
    localparam logic [W-1:0] SEED = 11'b11011011011;
    localparam int          SEQ_LEN = 8192;

    logic clk;
    logic reset_n;
    logic ld;
    logic en;
    logic dout;
`ifdef LFSR_LOCKUP_RECOVERY_EN
    logic lockup;
`endif

    int tests_run;
    int tests_failed;

    // Model: the output stream as a bit sequence from the seed; state at position k is seq[k .. k+W-1], MSB first.
    bit   seq [SEQ_LEN];
    logic m_zero;
    int   m_k;
    logic m_dout;
    logic m_lock;

    lfsr #(
        .LFSR_WIDTH      (W),
        .LFSR_POLYNOMIAL (POLY),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ld      (ld),
        .en      (en),
        .dout    (dout)
`ifdef LFSR_LOCKUP_RECOVERY_EN
        ,
        .lockup  (lockup)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_state();
        logic [W-1:0] s;
        s = '0;
        if (!m_zero) begin
            for (int b = 0; b < W; b++) s[W-1-b] = seq[m_k + b];
        end
        return s;
    endfunction

    function automatic logic model_msb();
        return m_zero ? 1'b0 : logic'(seq[m_k]);
    endfunction

    task automatic model_edge(input logic e, input logic l);
        m_lock = 1'b0;
        if (e) begin
            m_dout = model_msb();
            if (l) begin
                m_zero = 1'b0;
                m_k    = 0;
            end else if (m_zero) begin
`ifdef LFSR_LOCKUP_RECOVERY_EN
                m_zero = 1'b0;
                m_k    = 0;
                m_lock = 1'b1;
`endif
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 64'(dut.state), 64'(model_state()));
        check({tag, "_dout"}, 64'(dout), 64'(m_dout));
`ifdef LFSR_LOCKUP_RECOVERY_EN
        check({tag, "_lockup"}, 64'(lockup), 64'(m_lock));
`endif
    endtask

    task automatic step(input logic e, input logic l, input string tag);
        @(negedge clk);
        en = e;
        ld = l;
        @(posedge clk);
        #1;
        model_edge(e, l);
        check_all(tag);
    endtask

    task automatic model_reset();
        m_zero = 1'b1;
        m_k    = 0;
        m_dout = 1'b0;
        m_lock = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_dout;
        int first_ret;
        int zero_seen;

        tests_run    = 0;
        tests_failed = 0;
        for (int b = 0; b < W; b++) seq[b] = SEED[W-1-b];
        for (int n = W; n < SEQ_LEN; n++) begin
            bit x;
            x = 1'b0;
            for (int i = 0; i < W; i++) if (POLY[i]) x ^= seq[n-1-i];
            seq[n] = x;
        end
        exp_dout = 4'b1101;

        // Reset for two cycles, then idle with en low.
        reset_n = 1'b0;
        en      = 1'b0;
        ld      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(dut.state), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "idle");
        step(1'b0, 1'b1, "idle_ld_no_en");

        // Stepping from the all-zero state.
        step(1'b1, 1'b0, "lock0");
`ifdef LFSR_LOCKUP_RECOVERY_EN
        check("lock_pulse", 64'(lockup), 64'd1);
        check("lock_seed", 64'(dut.state), 64'(SEED));
`else
        check("lock_stuck", 64'(dut.state), 64'd0);
`endif
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "lock_run");

        // Load and run with known values.
        step(1'b1, 1'b1, "load");
        check("load_seed", 64'(dut.state), 64'(11'b11011011011));
        step(1'b1, 1'b0, "run1");
        check("run1_lit", 64'(dut.state), 64'(11'b10110110111));
        check("dout1_lit", 64'(dout), 64'(exp_dout[3]));
        step(1'b1, 1'b0, "run2");
        check("run2_lit", 64'(dut.state), 64'(11'b01101101110));
        check("dout2_lit", 64'(dout), 64'(exp_dout[2]));
        step(1'b1, 1'b0, "run3");
        check("run3_lit", 64'(dut.state), 64'(11'b11011011101));
        check("dout3_lit", 64'(dout), 64'(exp_dout[1]));
        step(1'b1, 1'b0, "run4");
        check("dout4_lit", 64'(dout), 64'(exp_dout[0]));

        // Enable gating with a stray ld during the freeze.
        step(1'b0, 1'b0, "gate1");
        step(1'b0, 1'b1, "gate2");
        step(1'b0, 1'b0, "gate3");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "resume");

        // Asynchronous reset between edges.
        @(negedge clk);
        en = 1'b1;
        ld = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_dout", 64'(dout), 64'd0);
        check("async_rst_state", 64'(dut.state), 64'd0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b1, "reload");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, "rerun");
            check("rerun_dout_lit", 64'(dout), 64'(exp_dout[3-i]));
        end

        // Random en/ld traffic.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0), "rand");
        end

        // Full period from the seed.
        step(1'b1, 1'b1, "per_load");
        first_ret = 0;
        zero_seen = 0;
        for (int i = 1; i <= 2047; i++) begin
            step(1'b1, 1'b0, "per");
            if (dut.state == '0) zero_seen++;
            if (first_ret == 0 && dut.state == SEED) first_ret = i;
        end
        check("period_len", 64'(first_ret), 64'd2047);
        check("period_zero", 64'(zero_seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
